// File: rtl/display_pkg.sv
// Shared types and defaults for the display arbiter.
// The GAP state is only present when DISP_BLANK_EN is defined.
package display_pkg;

  localparam int DISP_W_DEF  = 14;
  localparam int NUM_SRC_DEF = 4;

`ifdef DISP_BLANK_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester after last_grant, wrapping.
module rr_pick #(
  parameter  int NUM_SRC = 4,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last_grant,
  output logic [SRC_W-1:0]   grant_idx,
  output logic               grant_vld
);

  int pos;

  // Scan from the farthest candidate to the nearest so the nearest request wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    pos       = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      pos = (int'(last_grant) + k) % NUM_SRC;
      if (req[pos[SRC_W-1:0]]) begin
        grant_idx = pos[SRC_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter that shows one source value at a time on a binary display.
// Define DISP_BLANK_EN to insert a blank GAP phase between displayed items.
module display_arbiter
  import display_pkg::*;
#(
  parameter  int NUM_SRC     = NUM_SRC_DEF,
  parameter  int DISP_W      = DISP_W_DEF,
  parameter  int HOLD_CYCLES = 1000,
  parameter  int GAP_CYCLES  = 4,
  localparam int SRC_W       = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        req,
  input  logic [NUM_SRC*DISP_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        ack,
  output logic [DISP_W-1:0]         disp_value,
  output logic [SRC_W-1:0]          disp_src,
  output logic                      disp_valid,
  output logic                      busy
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [SRC_W-1:0]     last_grant_q, last_grant_d;
  logic [DISP_W-1:0]    disp_value_q, disp_value_d;
  logic [SRC_W-1:0]     disp_src_q, disp_src_d;
  logic                 disp_valid_q, disp_valid_d;
  logic [NUM_SRC-1:0]   ack_q, ack_d;
  logic                 arb;
  logic [SRC_W-1:0]     grant_idx;
  logic                 grant_vld;
  logic [DISP_W-1:0]    src_arr [NUM_SRC];

`ifdef DISP_BLANK_EN
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
`else
  logic                 unused_gap;
  assign unused_gap = |GAP_CYCLES;
`endif

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_arr[gi] = src_data[gi*DISP_W +: DISP_W];
  end

  rr_pick #(.NUM_SRC(NUM_SRC)) u_rr_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_grant_d = last_grant_q;
    disp_value_d = disp_value_q;
    disp_src_d   = disp_src_q;
    disp_valid_d = disp_valid_q;
    ack_d        = '0;
    arb          = 1'b0;
`ifdef DISP_BLANK_EN
    gap_cnt_d    = gap_cnt_q;
`endif

    case (state_q)
      IDLE: arb = 1'b1;
      HOLD: begin
        if (hold_cnt_q == '0) begin
`ifdef DISP_BLANK_EN
          state_d      = GAP;
          gap_cnt_d    = GAP_W'(GAP_CYCLES - 1);
          disp_value_d = '0;
          disp_valid_d = 1'b0;
`else
          arb = 1'b1;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
`ifdef DISP_BLANK_EN
      GAP: begin
        if (gap_cnt_q == '0) arb = 1'b1;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // req is only looked at here, so a request that drops earlier is simply lost.
    if (arb) begin
      if (grant_vld) begin
        state_d          = HOLD;
        hold_cnt_d       = CNT_W'(HOLD_CYCLES - 1);
        last_grant_d     = grant_idx;
        disp_src_d       = grant_idx;
        disp_value_d     = src_arr[grant_idx];
        disp_valid_d     = 1'b1;
        ack_d[grant_idx] = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      last_grant_q <= SRC_W'(NUM_SRC - 1);
      disp_value_q <= '0;
      disp_src_q   <= '0;
      disp_valid_q <= 1'b0;
      ack_q        <= '0;
`ifdef DISP_BLANK_EN
      gap_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_grant_q <= last_grant_d;
      disp_value_q <= disp_value_d;
      disp_src_q   <= disp_src_d;
      disp_valid_q <= disp_valid_d;
      ack_q        <= ack_d;
`ifdef DISP_BLANK_EN
      gap_cnt_q    <= gap_cnt_d;
`endif
    end
  end

  assign ack        = ack_q;
  assign disp_value = disp_value_q;
  assign disp_src   = disp_src_q;
  assign disp_valid = disp_valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter against a slot-occupancy reference model.
// Works with or without DISP_BLANK_EN defined.
module tb_display_arbiter;

  localparam int N     = 4;
  localparam int W     = 14;
  localparam int HOLD  = 4;
  localparam int GAPC  = 2;
  localparam int SW    = $clog2(N);
`ifdef DISP_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam int TOTAL = HOLD + (BLANK ? GAPC : 0);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] src_data = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   disp_value;
  logic [SW-1:0]  disp_src;
  logic           disp_valid;
  logic           busy;

  int errors = 0;
  int checks = 0;

  // reference model: an item occupies TOTAL clocks, the last GAP of them blanked
  logic [N-1:0]   m_ack;
  logic [W-1:0]   m_value;
  logic [SW-1:0]  m_src;
  logic           m_valid;
  logic           m_busy;
  int             m_last;
  int             m_age;

  always #5 clk = ~clk;

  display_arbiter #(
    .NUM_SRC(N), .DISP_W(W), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_data(src_data),
    .ack(ack), .disp_value(disp_value), .disp_src(disp_src),
    .disp_valid(disp_valid), .busy(busy)
  );

  task automatic model_reset();
    m_ack = '0; m_value = '0; m_src = '0; m_valid = 1'b0; m_busy = 1'b0;
    m_last = N - 1; m_age = 0;
  endtask

  task automatic model_edge();
    int pick;
    pick  = -1;
    m_ack = '0;
    if (m_busy && (m_age + 1 < TOTAL)) begin
      m_age++;
      if (m_age == HOLD) begin
        m_value = '0;
        m_valid = 1'b0;
      end
    end else begin
      for (int k = N; k >= 1; k--)
        if (req[(m_last + k) % N]) pick = (m_last + k) % N;
      if (pick >= 0) begin
        m_busy      = 1'b1;
        m_age       = 0;
        m_last      = pick;
        m_src       = pick[SW-1:0];
        m_value     = src_data[pick*W +: W];
        m_valid     = 1'b1;
        m_ack[pick] = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (ack != '0)
      $display("grant ack=%b src=%0d value=%h t=%0t", ack, disp_src, disp_value, $time);
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = '0; src_data = '0;
    do_reset();
    checks++;
    if ({ack, disp_value, disp_src, disp_valid, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state got ack=%b val=%h src=%0d vld=%b busy=%b want all zero",
               ack, disp_value, disp_src, disp_valid, busy);
    end
  endtask

  task automatic test_single();
    int cnt;
    do_reset();
    src_data = {$urandom(), $urandom()};
    src_data[W-1:0] = 14'h1555;
    req = 4'b0001;
    tick();
    checks++;
    if (ack !== 4'b0001 || disp_value !== 14'h1555 || disp_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got ack=%b val=%h vld=%b want 0001 1555 1",
               ack, disp_value, disp_valid);
    end
    req = '0;
    cnt = 1;
    for (int c = 0; c < TOTAL + 3; c++) begin
      tick();
      if (disp_valid && busy) cnt++;
      checks++;
      if ({ack, disp_value, disp_src, disp_valid, busy} !== {m_ack, m_value, m_src, m_valid, m_busy}) begin
        errors++;
        $display("FAIL single_seq got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", ack, disp_value,
                 disp_src, disp_valid, busy, m_ack, m_value, m_src, m_valid, m_busy);
      end
    end
    checks++;
    if (cnt != HOLD || busy !== 1'b0 || disp_value !== (BLANK ? 14'h0 : 14'h1555)) begin
      errors++;
      $display("FAIL single_hold got cycles=%0d busy=%b val=%h want cycles=%0d idle retained",
               cnt, busy, disp_value, HOLD);
    end
  endtask

  task automatic test_round_robin();
    int g_idx[$];
    int g_cyc[$];
    do_reset();
    src_data = {$urandom(), $urandom()};
    req = 4'b1111;
    for (int c = 0; c < 4 * TOTAL + 1; c++) begin
      tick();
      if (ack != '0) begin
        g_idx.push_back(onehot_idx(ack));
        g_cyc.push_back(c);
      end
      checks++;
      if ({ack, disp_value, disp_src, disp_valid, busy} !== {m_ack, m_value, m_src, m_valid, m_busy}) begin
        errors++;
        $display("FAIL rr_seq got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", ack, disp_value,
                 disp_src, disp_valid, busy, m_ack, m_value, m_src, m_valid, m_busy);
      end
    end
    req = '0;
    checks++;
    if (g_idx.size() != 5) begin
      errors++;
      $display("FAIL rr_count got %0d grants want 5", g_idx.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (g_idx[i] != (i % N) || g_cyc[i] != i * TOTAL) begin
          errors++;
          $display("FAIL rr_order grant%0d got src=%0d cyc=%0d want src=%0d cyc=%0d",
                   i, g_idx[i], g_cyc[i], i % N, i * TOTAL);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int g_idx[$];
    do_reset();
    src_data = {$urandom(), $urandom()};
    req = 4'b0100;
    tick();
    checks++;
    if (ack !== 4'b0100) begin
      errors++;
      $display("FAIL wrap_first got ack=%b want 0100", ack);
    end
    req = 4'b0101;
    for (int c = 0; c < 2 * TOTAL; c++) begin
      tick();
      if (ack != '0) g_idx.push_back(onehot_idx(ack));
    end
    req = '0;
    checks++;
    if (g_idx.size() != 2 || g_idx[0] != 0 || g_idx[1] != 2) begin
      errors++;
      $display("FAIL wrap_order got %0d grants first=%0d second=%0d want 0 then 2",
               g_idx.size(), (g_idx.size() > 0) ? g_idx[0] : -1, (g_idx.size() > 1) ? g_idx[1] : -1);
    end
  endtask

  task automatic test_data_change();
    logic [W-1:0] saved;
    do_reset();
    src_data = {$urandom(), $urandom()};
    req = 4'b0010;
    tick();
    saved = src_data[W +: W];
    req = '0;
    for (int c = 0; c < HOLD - 1; c++) begin
      src_data = {$urandom(), $urandom()};
      tick();
      checks++;
      if (disp_value !== saved || disp_value !== m_value) begin
        errors++;
        $display("FAIL data_hold got val=%h want %h", disp_value, saved);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    src_data = {$urandom(), $urandom()};
    req = 4'b1111;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ack, disp_value, disp_src, disp_valid, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset got ack=%b val=%h src=%0d vld=%b busy=%b want all zero",
               ack, disp_value, disp_src, disp_valid, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (ack !== 4'b0001 || disp_src !== 2'd0 || disp_value !== src_data[W-1:0]) begin
      errors++;
      $display("FAIL post_reset_grant got ack=%b src=%0d want ack=0001 src=0", ack, disp_src);
    end
    req = '0;
  endtask

  task automatic test_blank_seq();
    logic [W-1:0] a, b, ev;
    logic         evld;
    do_reset();
    src_data = {$urandom(), $urandom()};
    a = src_data[0 +: W];
    b = src_data[W +: W];
    req = 4'b0011;
    for (int c = 0; c <= TOTAL; c++) begin
      tick();
      if (c < HOLD)       begin ev = a;  evld = 1'b1; end
      else if (c < TOTAL) begin ev = '0; evld = 1'b0; end
      else                begin ev = b;  evld = 1'b1; end
      checks++;
      if (disp_value !== ev || disp_valid !== evld) begin
        errors++;
        $display("FAIL display_seq cycle%0d got val=%h vld=%b want val=%h vld=%b",
                 c, disp_value, disp_valid, ev, evld);
      end
    end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom());
      src_data = {$urandom(), $urandom()};
      tick();
      checks++;
      if ({ack, disp_value, disp_src, disp_valid, busy} !== {m_ack, m_value, m_src, m_valid, m_busy}) begin
        errors++;
        $display("FAIL random c%0d got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", c, ack, disp_value,
                 disp_src, disp_valid, busy, m_ack, m_value, m_src, m_valid, m_busy);
      end
    end
    req = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_data_change();
    test_reset_mid_hold();
    test_blank_seq();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Parameter SHALL be: NUM_SRC, 4, number of requesters (2..8).
REQ-003 Parameter SHALL be: DISP_W, 14, display word width; it matches the 14-digit binary display input.
REQ-004 Parameter SHALL be: HOLD_CYCLES, 1000, clocks each granted value stays on the display (>=1).
REQ-005 Parameter SHALL be: GAP_CYCLES, 4, blank clocks between items (used only with DISP_BLANK_EN, >=1).
REQ-006 Port SHALL be: clk  input  1  rising-edge clock.
REQ-007 Port SHALL be: rst_n  input  1  asynchronous active-low reset.
REQ-008 Port SHALL be: req  input  NUM_SRC  level request, one bit per source.
REQ-009 Port SHALL be: src_data  input  NUM_SRC*DISP_W  packed source values; source i occupies bits [i*DISP_W +: DISP_W].
REQ-010 Port SHALL be: ack  output  NUM_SRC  one-cycle one-hot grant pulse, asserted on the capture cycle.
REQ-011 Port SHALL be: disp_value  output  DISP_W  registered value that drives the binary display.
REQ-012 Port SHALL be: disp_src  output  clog2(NUM_SRC)  index of the source being shown.
REQ-013 Port SHALL be: disp_valid  output  1  high while disp_value holds a granted item.
REQ-014 Port SHALL be: busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, HOLD and GAP; GAP SHALL exist only with DISP_BLANK_EN.
REQ-016 IDLE with req!=0: on the next edge the block SHALL grant one source round-robin, starting the search at last_grant+1 modulo NUM_SRC.
REQ-017 The same edge SHALL load disp_value and disp_src, set disp_valid=1, pulse ack[i] for exactly one cycle, load hold_cnt=HOLD_CYCLES-1 and enter HOLD; grant latency is one clock.
REQ-018 In HOLD, hold_cnt SHALL decrement each clock; when hold_cnt==0 the next state SHALL be GAP (macro on) or the arbitration step of REQ-016 (macro off).
REQ-019 With the macro off and req!=0 at hold expiry, the block SHALL grant back-to-back with no idle cycle.
REQ-020 With the macro off and req==0 at hold expiry, the block SHALL return to IDLE; disp_value, disp_src and disp_valid SHALL keep their last values.
REQ-021 req SHALL be sampled only at arbitration points; a req that drops before being sampled SHALL be dropped silently with no ack.
REQ-022 A req still high after its ack SHALL count as a new request and SHALL wait behind any other pending source, so no source starves.
REQ-023 The HOLD_CYCLES=1 boundary case SHALL hold each item for exactly one clock.
REQ-024 src_data SHALL be sampled only on the grant edge; later changes SHALL NOT affect disp_value.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, ack=0, disp_value=0, disp_src=0, disp_valid=0, busy=0 and hold_cnt=0.
REQ-026 Reset SHALL set last_grant=NUM_SRC-1 so that source 0 has first priority after reset.
REQ-027 Reset asserted during HOLD or GAP SHALL abandon the current item with no ack; the first grant after release SHALL follow REQ-026.

Configuration
REQ-028 When macro DISP_BLANK_EN is defined, hold expiry SHALL enter GAP for GAP_CYCLES clocks with disp_value=0 and disp_valid=0, then run the arbitration step of REQ-016 (or go to IDLE).
REQ-029 When DISP_BLANK_EN is undefined, GAP logic and the gap counter SHALL be absent and REQ-019/REQ-020 SHALL apply.

Structure
REQ-030 Package display_pkg SHALL hold the state encoding (IDLE, HOLD, GAP), the DISP_W default of 14 and the NUM_SRC default of 4.
REQ-031 The round-robin search SHALL be a combinational sub-module rr_pick with inputs req and last_grant and outputs grant_idx and grant_vld.

Verification (HOLD_CYCLES=4, GAP_CYCLES=2, NUM_SRC=4)
REQ-032 The bench SHALL check: after reset, req=0001 with src0=14'h1555 -> ack=0001 on the first edge, disp_value=14'h1555, disp_valid=1, held 4 clocks, then IDLE with the value retained.
REQ-033 The bench SHALL check: req=1111 held steady -> grants in order 0,1,2,3,0, each 4 clocks apart with no idle cycle (macro off).
REQ-034 The bench SHALL check: after a grant to source 2, req=0101 -> next grant is source 0 (wrap past 3), then source 2.
REQ-035 The bench SHALL check: src_data changes during HOLD -> disp_value unchanged until the next grant.
REQ-036 The bench SHALL check: rst_n low for one cycle mid-HOLD -> all outputs 0 immediately, and with req=1111 the first grant after release is source 0.
REQ-037 The bench SHALL check: with DISP_BLANK_EN and req=0011 -> display sequence is src0 for 4 clocks, 0 with disp_valid=0 for 2 clocks, then src1.
